// File: rtl/vip_frame_arb_pkg.sv
// vip_pkg: shared header field positions, FSM state type and frame size helper for the frame arbiter
package vip_pkg;
  localparam int CTRL_W = 36;
  localparam int WIDTH_MSB = 35;
  localparam int WIDTH_LSB = 20;
  localparam int HEIGHT_MSB = 19;
  localparam int HEIGHT_LSB = 4;
  typedef enum logic [1:0] {IDLE, CTRL, VIDEO, DRAIN} arb_state_t;
  function automatic logic [31:0] frame_beats(input logic [CTRL_W-1:0] hdr, input int p);
    return (32'(hdr[WIDTH_MSB:WIDTH_LSB]) >> p) * 32'(hdr[HEIGHT_MSB:HEIGHT_LSB]);
  endfunction
endpackage

// File: rtl/vip_frame_arb_if.sv
// vip_frame_arb_if: requester, post-side and status signals of the frame arbiter
interface vip_frame_arb_if import vip_pkg::*; #(parameter int BITWIDTH = 32) ();
  logic [CTRL_W-1:0]   rq0_control_data;
  logic                rq0_control_valid;
  logic                rq0_control_ready;
  logic [BITWIDTH-1:0] rq0_video_data;
  logic                rq0_video_valid;
  logic                rq0_video_ready;
  logic [CTRL_W-1:0]   rq1_control_data;
  logic                rq1_control_valid;
  logic                rq1_control_ready;
  logic [BITWIDTH-1:0] rq1_video_data;
  logic                rq1_video_valid;
  logic                rq1_video_ready;
  logic [CTRL_W-1:0]   out_control_data;
  logic                out_control_valid;
  logic [BITWIDTH-1:0] out_video_data;
  logic                out_video_valid;
  logic                out_video_ready;
  logic                post_frame_end;
  logic [1:0]          grant;
  logic                size_err;
  modport slave (
    input  rq0_control_data, rq0_control_valid, rq0_video_data, rq0_video_valid,
    input  rq1_control_data, rq1_control_valid, rq1_video_data, rq1_video_valid,
    input  out_video_ready, post_frame_end,
    output rq0_control_ready, rq0_video_ready, rq1_control_ready, rq1_video_ready,
    output out_control_data, out_control_valid, out_video_data, out_video_valid,
    output grant, size_err
  );
  modport master (
    output rq0_control_data, rq0_control_valid, rq0_video_data, rq0_video_valid,
    output rq1_control_data, rq1_control_valid, rq1_video_data, rq1_video_valid,
    output out_video_ready, post_frame_end,
    input  rq0_control_ready, rq0_video_ready, rq1_control_ready, rq1_video_ready,
    input  out_control_data, out_control_valid, out_video_data, out_video_valid,
    input  grant, size_err
  );
endinterface

// File: rtl/vip_frame_arb_rr.sv
// vip_rr_pick2: two-way round-robin pick; on a tie the requester not served last wins
module vip_rr_pick2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic [1:0] upd_gnt_i,
  output logic [1:0] gnt_o
);
  logic [1:0] last_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= 2'b10;
    else if (upd_i) last_q <= upd_gnt_i;
  always_comb
    gnt_o = !en_i ? 2'b00 : (&req_i) ? ~last_q : req_i;
endmodule

// File: rtl/vip_frame_arb.sv
// vip_frame_arb: round-robin frame arbiter steering one header and one frame of beats
// from either of two requesters into the shared post stage.
module vip_frame_arb import vip_pkg::*; #(
  parameter int BITWIDTH = 32,
  parameter int PARALLEL_BITWIDTH = 0
) (
  input logic clk,
  input logic rst,
  vip_frame_arb_if.slave bus
);
  arb_state_t          state_q;
  logic [1:0]          grant_q, pick;
  logic [CTRL_W-1:0]   hdr_q, hdr_in;
  logic [31:0]         beats_q, beats_d, cnt_q;
  logic                ctrl_v_q, size_err_q;
  logic                idle, hs_ctrl, hs_video, last_beat, upd, vvalid;
  logic [BITWIDTH-1:0] vdata;
  assign idle = state_q == IDLE;
  vip_rr_pick2 u_pick (
    .clk      (clk),
    .rst      (rst),
    .en_i     (idle && !rst),
    .req_i    ({bus.rq1_control_valid, bus.rq0_control_valid}),
    .upd_i    (upd),
    .upd_gnt_i(idle ? pick : grant_q),
    .gnt_o    (pick)
  );
  assign hs_ctrl = |pick;
  assign hdr_in = pick[1] ? bus.rq1_control_data : bus.rq0_control_data;
  assign beats_d = frame_beats(hdr_in, PARALLEL_BITWIDTH);
  // zero-size rejects still advance the rotation so a bad requester cannot starve the other
  assign upd = (hs_ctrl && beats_d == '0) || (state_q == DRAIN && bus.post_frame_end);
  assign vdata = grant_q[1] ? bus.rq1_video_data : bus.rq0_video_data;
  assign vvalid = state_q == VIDEO && (grant_q[1] ? bus.rq1_video_valid : bus.rq0_video_valid);
  assign hs_video = vvalid && bus.out_video_ready;
  assign last_beat = cnt_q == beats_q - 32'd1;
  assign bus.rq0_control_ready = pick[0];
  assign bus.rq1_control_ready = pick[1];
  assign bus.rq0_video_ready = state_q == VIDEO && grant_q[0] && bus.out_video_ready;
  assign bus.rq1_video_ready = state_q == VIDEO && grant_q[1] && bus.out_video_ready;
  assign bus.out_control_data = hdr_q;
  assign bus.out_control_valid = ctrl_v_q;
  assign bus.out_video_data = vdata;
  assign bus.out_video_valid = vvalid;
  assign bus.grant = grant_q;
  assign bus.size_err = size_err_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      hdr_q <= '0;
      beats_q <= '0;
      cnt_q <= '0;
      ctrl_v_q <= 1'b0;
      size_err_q <= 1'b0;
    end else begin
      size_err_q <= 1'b0;
      ctrl_v_q <= 1'b0;
      case (state_q)
        IDLE: if (hs_ctrl) begin
          hdr_q <= hdr_in;
          beats_q <= beats_d;
          if (beats_d == '0) size_err_q <= 1'b1;
          else begin
            grant_q <= pick;
            ctrl_v_q <= 1'b1;
            state_q <= CTRL;
          end
        end
        CTRL: begin
          cnt_q <= '0;
          state_q <= VIDEO;
        end
        VIDEO: if (hs_video) begin
          cnt_q <= cnt_q + 32'd1;
          if (last_beat) state_q <= DRAIN;
        end
        DRAIN: if (bus.post_frame_end) begin
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_vip_frame_arb.sv
// tb_vip_frame_arb: directed checks of arbitration, framing, flow control, size rejects and reset
module tb_vip_frame_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int ncmp = 0;
  int nfail = 0;
  vip_frame_arb_if #(.BITWIDTH(32)) bi0 ();
  vip_frame_arb_if #(.BITWIDTH(32)) bi1 ();
  vip_frame_arb #(.BITWIDTH(32), .PARALLEL_BITWIDTH(0)) dut0 (.clk(clk), .rst(rst), .bus(bi0.slave));
  vip_frame_arb #(.BITWIDTH(32), .PARALLEL_BITWIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bi1.slave));
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] beat(input bit r, input int k);
    return {r ? 16'hB1B1 : 16'hB0B0, 16'(k)};
  endfunction
  task automatic frame(input bit r, input logic [35:0] hdr, input int n);
    logic [1:0] g;
    g = r ? 2'b10 : 2'b01;
    if (r) begin
      bi0.rq1_control_data = hdr;
      bi0.rq1_control_valid = 1'b1;
    end else begin
      bi0.rq0_control_data = hdr;
      bi0.rq0_control_valid = 1'b1;
    end
    #1;
    chk("ctrl_ready", {bi0.rq1_control_ready, bi0.rq0_control_ready}, g);
    cyc();
    if (r) bi0.rq1_control_valid = 1'b0;
    else bi0.rq0_control_valid = 1'b0;
    chk("ctrl_valid", bi0.out_control_valid, 1'b1);
    chk("ctrl_data", bi0.out_control_data, hdr);
    chk("grant", bi0.grant, g);
    cyc();
    chk("ctrl_pulse_end", bi0.out_control_valid, 1'b0);
    bi0.out_video_ready = 1'b1;
    bi0.rq0_video_valid = 1'b1;
    bi0.rq1_video_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      bi0.rq0_video_data = beat(1'b0, k);
      bi0.rq1_video_data = beat(1'b1, k);
      #1;
      chk("vid_data", bi0.out_video_data, beat(r, k));
      chk("other_vready", r ? bi0.rq0_video_ready : bi0.rq1_video_ready, 1'b0);
      cyc();
    end
    chk("drain_vvalid", bi0.out_video_valid, 1'b0);
    chk("drain_vready", r ? bi0.rq1_video_ready : bi0.rq0_video_ready, 1'b0);
    bi0.post_frame_end = 1'b1;
    #1;
    chk("drain_grant", bi0.grant, g);
    chk("drain_no_ctrl", {bi0.rq1_control_ready, bi0.rq0_control_ready}, 2'b00);
    cyc();
    bi0.post_frame_end = 1'b0;
    bi0.rq0_video_valid = 1'b0;
    bi0.rq1_video_valid = 1'b0;
    chk("grant_idle", bi0.grant, 2'b00);
  endtask
  initial begin
    bi0.rq0_control_data = '0; bi0.rq0_control_valid = 1'b0; bi0.rq0_video_data = '0; bi0.rq0_video_valid = 1'b0;
    bi0.rq1_control_data = '0; bi0.rq1_control_valid = 1'b0; bi0.rq1_video_data = '0; bi0.rq1_video_valid = 1'b0;
    bi0.out_video_ready = 1'b0; bi0.post_frame_end = 1'b0;
    bi1.rq0_control_data = '0; bi1.rq0_control_valid = 1'b0; bi1.rq0_video_data = '0; bi1.rq0_video_valid = 1'b0;
    bi1.rq1_control_data = '0; bi1.rq1_control_valid = 1'b0; bi1.rq1_video_data = '0; bi1.rq1_video_valid = 1'b0;
    bi1.out_video_ready = 1'b0; bi1.post_frame_end = 1'b0;
    // both requesters already waiting when reset releases
    bi0.rq0_control_data = {16'd2, 16'd1, 4'd0};
    bi0.rq1_control_data = {16'd1, 16'd2, 4'd0};
    bi0.rq0_control_valid = 1'b1;
    bi0.rq1_control_valid = 1'b1;
    repeat (2) cyc();
    chk("rst_grant", bi0.grant, 2'b00);
    chk("rst_cvalid", bi0.out_control_valid, 1'b0);
    chk("rst_cdata", bi0.out_control_data, 36'd0);
    chk("rst_vvalid", bi0.out_video_valid, 1'b0);
    chk("rst_size_err", bi0.size_err, 1'b0);
    chk("rst_cready", {bi0.rq1_control_ready, bi0.rq0_control_ready}, 2'b00);
    rst = 1'b0;
    frame(1'b0, {16'd2, 16'd1, 4'd0}, 2);
    bi0.rq0_control_valid = 1'b1;
    frame(1'b1, {16'd1, 16'd2, 4'd0}, 2);
    bi0.rq1_control_valid = 1'b1;
    frame(1'b0, {16'd2, 16'd1, 4'd0}, 2);
    bi0.rq0_control_valid = 1'b1;
    frame(1'b1, {16'd1, 16'd2, 4'd0}, 2);
    bi0.rq0_control_valid = 1'b0;
    cyc();
    frame(1'b0, {16'd8, 16'd2, 4'd0}, 16);
    // flow control: ready toggles, 4 beats over 8 cycles
    bi0.rq0_control_data = {16'd4, 16'd1, 4'd0};
    bi0.rq0_control_valid = 1'b1;
    cyc();
    bi0.rq0_control_valid = 1'b0;
    chk("t_cvalid", bi0.out_control_valid, 1'b1);
    cyc();
    bi0.rq0_video_valid = 1'b1;
    bi0.rq1_video_valid = 1'b1;
    bi0.rq1_video_data = 32'hDEAD_BEEF;
    begin
      int k;
      k = 0;
      for (int i = 0; i < 8; i++) begin
        bi0.out_video_ready = (i % 2) == 0;
        bi0.rq0_video_data = beat(1'b0, k);
        #1;
        chk("t_rq1_vready", bi0.rq1_video_ready, 1'b0);
        chk("t_vvalid", bi0.out_video_valid, i < 7);
        if ((i % 2) == 0) chk("t_data", bi0.out_video_data, beat(1'b0, k));
        cyc();
        if ((i % 2) == 0) k++;
      end
    end
    bi0.out_video_ready = 1'b1;
    #1;
    chk("t_drain_vready", bi0.rq0_video_ready, 1'b0);
    bi0.post_frame_end = 1'b1;
    cyc();
    bi0.post_frame_end = 1'b0;
    bi0.rq0_video_valid = 1'b0;
    bi0.rq1_video_valid = 1'b0;
    chk("t_grant_idle", bi0.grant, 2'b00);
    // zero-size headers
    bi0.rq0_control_data = {16'd0, 16'd5, 4'd0};
    bi0.rq0_control_valid = 1'b1;
    #1;
    chk("z_cready", {bi0.rq1_control_ready, bi0.rq0_control_ready}, 2'b01);
    cyc();
    chk("z_size_err", bi0.size_err, 1'b1);
    chk("z_no_cvalid", bi0.out_control_valid, 1'b0);
    bi0.rq0_control_data = {16'd4, 16'd0, 4'd0};
    #1;
    chk("z_idle_cready", {bi0.rq1_control_ready, bi0.rq0_control_ready}, 2'b01);
    cyc();
    bi0.rq0_control_valid = 1'b0;
    chk("z_size_err2", bi0.size_err, 1'b1);
    chk("z_no_cvalid2", bi0.out_control_valid, 1'b0);
    cyc();
    chk("z_size_err_clr", bi0.size_err, 1'b0);
    chk("z_grant", bi0.grant, 2'b00);
    // parallel beats: (7>>1)*3 = 9
    bi1.rq0_control_data = {16'd7, 16'd3, 4'd0};
    bi1.rq0_control_valid = 1'b1;
    cyc();
    bi1.rq0_control_valid = 1'b0;
    chk("p_cvalid", bi1.out_control_valid, 1'b1);
    cyc();
    bi1.out_video_ready = 1'b1;
    bi1.rq0_video_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      bi1.rq0_video_data = 32'd100 + 32'(k);
      #1;
      chk("p_data", bi1.out_video_data, 32'd100 + 32'(k));
      cyc();
    end
    bi1.rq0_video_data = 32'd109;
    #1;
    chk("p_10th_vready", bi1.rq0_video_ready, 1'b0);
    chk("p_10th_vvalid", bi1.out_video_valid, 1'b0);
    bi1.post_frame_end = 1'b1;
    cyc();
    bi1.post_frame_end = 1'b0;
    bi1.rq0_video_valid = 1'b0;
    chk("p_grant_idle", bi1.grant, 2'b00);
    // reset during beat 5 of 16
    bi0.rq0_control_data = {16'd16, 16'd1, 4'd0};
    bi0.rq0_control_valid = 1'b1;
    cyc();
    bi0.rq0_control_valid = 1'b0;
    cyc();
    bi0.out_video_ready = 1'b1;
    bi0.rq0_video_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bi0.rq0_video_data = beat(1'b0, k);
      cyc();
    end
    bi0.rq0_video_data = beat(1'b0, 4);
    #1;
    chk("r_mid_vvalid", bi0.out_video_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("r_grant", bi0.grant, 2'b00);
    chk("r_vvalid", bi0.out_video_valid, 1'b0);
    chk("r_vready", bi0.rq0_video_ready, 1'b0);
    chk("r_cdata", bi0.out_control_data, 36'd0);
    chk("r_cvalid", bi0.out_control_valid, 1'b0);
    bi0.rq0_video_valid = 1'b0;
    bi0.out_video_ready = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    frame(1'b0, {16'd2, 16'd2, 4'd0}, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
